rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port (WR/WReg/WDATA) among NREQ writeback requesters, e.g. ALU, load unit and CSR/mul unit.
- Uses round-robin arbitration with a valid/ready handshake and one registered output stage.
- Keeps a 32-entry pending-write scoreboard and raises a read-hazard stall for the decode stage.
- Sits between the execution units and RegisterFile.

---
 rtl/rf_ctrl_pkg.sv | 42 ++++
 rtl/rr_arbiter.sv | 39 +++
 rtl/rf_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write-port control slice:
// register address constants and the rotate-priority pick used by the arbiter.
package rf_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    // Largest supported requester count; narrower configurations are zero-padded up to it.
    localparam int MAX_REQ   = 4;
    localparam int REQ_IDX_W = 2;

    typedef struct packed {
        logic                 found;
        logic [REQ_IDX_W-1:0] idx;
    } rr_pick_t;

    // Rotate-priority encode: scan req starting at ptr, wrapping at nreq.
    // The loop runs from the farthest offset down to offset 0, so the nearest
    // valid requester is the last one written and therefore wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                         input logic [REQ_IDX_W-1:0] ptr,
                                         input logic [2:0]           nreq);
        rr_pick_t   res;
        logic [2:0] pos;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (3'(k) < nreq) begin
                pos = {1'b0, ptr} + 3'(k);
                if (pos >= nreq) begin
                    pos = pos - nreq;
                end
                if (req[pos[REQ_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = pos[REQ_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester found
// when scanning from ptr upward with wrap-around. The pointer itself is owned
// by the instantiating module so it can be advanced only on real transfers.
module rr_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]      req,
    input  logic [REQ_IDX_W-1:0] ptr,
    output logic [NREQ-1:0]      grant,
    output logic [REQ_IDX_W-1:0] grant_idx,
    output logic                 any_grant
);

    logic [MAX_REQ-1:0] req_pad;
    logic [MAX_REQ-1:0] grant_pad;
    rr_pick_t           pick;

    // Widen the request vector to the fixed width the pick helper works on.
    always_comb begin
        req_pad            = '0;
        req_pad[NREQ-1:0]  = req;
    end

    // Pick the winner and build the one-hot grant from its index.
    always_comb begin
        pick      = rr_pick(req_pad, ptr, 3'(NREQ));
        grant_pad = '0;
        if (pick.found) begin
            grant_pad[pick.idx] = 1'b1;
        end
    end

    assign grant     = grant_pad[NREQ-1:0];
    assign grant_idx = pick.idx;
    assign any_grant = pick.found;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port. Requesters are
// served round-robin, the winning write goes through one register stage onto
// WR/WReg/WDATA, and a 32-entry scoreboard tracks destinations still in flight
// so decode can stall on read-after-write hazards.
module rf_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*REG_ADDR_W-1:0]   req_addr,
    input  logic [NREQ*N-1:0]            req_data,
    output logic [NREQ-1:0]              req_ready,
    input  logic                         issue_valid,
    input  logic [REG_ADDR_W-1:0]        issue_addr,
    input  logic [REG_ADDR_W-1:0]        rs1_addr,
    input  logic [REG_ADDR_W-1:0]        rs2_addr,
    output logic                         hazard_stall,
    output logic                         WR,
    output logic [REG_ADDR_W-1:0]        WReg,
    output logic [N-1:0]                 WDATA,
    output logic [NUM_REGS-1:0]          busy_vec
);

    logic [REQ_IDX_W-1:0]  ptr;
    logic [REQ_IDX_W-1:0]  grant_idx;
    logic                  any_grant;
    logic [REG_ADDR_W-1:0] addr_arr [MAX_REQ];
    logic [N-1:0]          data_arr [MAX_REQ];
    logic [REG_ADDR_W-1:0] win_addr;
    logic [N-1:0]          win_data;
    logic                  win_writes;
    logic [NUM_REGS-1:0]   busy_next;

    // Unpack the flat requester buses; slots beyond NREQ read as zero so the
    // winner mux can always be indexed with the full-width grant index.
    for (genvar i = 0; i < MAX_REQ; i++) begin : g_unpack
        if (i < NREQ) begin : g_used
            assign addr_arr[i] = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
            assign data_arr[i] = req_data[i*N +: N];
        end else begin : g_pad
            assign addr_arr[i] = '0;
            assign data_arr[i] = '0;
        end
    end

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Select the winning write; x0 targets are accepted but never reach the port.
    always_comb begin
        win_addr   = addr_arr[grant_idx];
        win_data   = data_arr[grant_idx];
        win_writes = any_grant && (win_addr != REG_X0);
    end

    // Advance the round-robin pointer past whoever was just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (any_grant) begin
            if (grant_idx == REQ_IDX_W'(NREQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

    // Register the write port; address and data hold when no write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            WR    <= 1'b0;
            WReg  <= '0;
            WDATA <= '0;
        end else begin
            WR <= win_writes;
            if (win_writes) begin
                WReg  <= win_addr;
                WDATA <= win_data;
            end
        end
    end

    // Scoreboard update: clear the register being written this edge, then
    // apply a new issue on top so a fresh producer keeps the register busy.
    always_comb begin
        busy_next = busy_vec;
        if (WR && (WReg != REG_X0)) begin
            busy_next[WReg] = 1'b0;
        end
        if (issue_valid && (issue_addr != REG_X0)) begin
            busy_next[issue_addr] = 1'b1;
        end
    end

    // Hold the pending-write scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

    // Stall decode while either source register still has a write in flight.
    always_comb begin
        hazard_stall = ((rs1_addr != REG_X0) && busy_vec[rs1_addr]) ||
                       ((rs2_addr != REG_X0) && busy_vec[rs2_addr]);
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, round-robin order, scoreboard
// lifecycle, x0 writes, simultaneous set/clear and reset mid-transfer.
module tb_rf_wb_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid;
    logic [14:0]   req_addr;
    logic [95:0]   req_data;
    logic [2:0]    req_ready;
    logic          issue_valid;
    logic [4:0]    issue_addr;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic          hazard_stall;
    logic          WR;
    logic [4:0]    WReg;
    logic [31:0]   WDATA;
    logic [31:0]   busy_vec;

    int checkCount = 0;
    int errorCount = 0;

    rf_wb_arbiter #(
        .N    (N),
        .NREQ (NREQ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .hazard_stall (hazard_stall),
        .WR           (WR),
        .WReg         (WReg),
        .WDATA        (WDATA),
        .busy_vec     (busy_vec)
    );

    always #5 clk = ~clk;

    // Decode must never issue to a register that is still pending, unless that
    // register's write lands on this very edge.
    always @(posedge clk) begin
        if (!rst && issue_valid && issue_addr != 5'd0) begin
            assert (!busy_vec[issue_addr] || (WR && WReg == issue_addr))
                else $error("[TB] issue to busy register %0d", issue_addr);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] valid,
                                 input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic iv, input logic [4:0] ia,
                                 input logic [4:0] r1, input logic [4:0] r2);
        req_valid   = valid;
        req_addr    = {a2, a1, a0};
        req_data    = {d2, d1, d0};
        issue_valid = iv;
        issue_addr  = ia;
        rs1_addr    = r1;
        rs2_addr    = r2;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        rst = 1'b1;
        applyStimulus(3'b111, 5'd5, 5'd6, 5'd7, 32'h100, 32'h101, 32'h102, 1'b0, 5'd0, 5'd0, 5'd0);
        stepClock();
        checkOutput("rst_wr",    64'(WR),       64'd0);
        checkOutput("rst_wreg",  64'(WReg),     64'd0);
        checkOutput("rst_wdata", 64'(WDATA),    64'd0);
        checkOutput("rst_busy",  64'(busy_vec), 64'd0);
        rst = 1'b0;

        // Round robin with all three valid: grants 0,1,2,0
        @(negedge clk); checkOutput("rr_g0", 64'(req_ready), 64'b001);
        stepClock();
        checkOutput("rr_wr0", 64'(WR), 64'd1);
        checkOutput("rr_wreg0", 64'(WReg), 64'd5);
        checkOutput("rr_wdata0", 64'(WDATA), 64'h100);
        @(negedge clk); checkOutput("rr_g1", 64'(req_ready), 64'b010);
        stepClock();
        checkOutput("rr_wr1", 64'(WR), 64'd1);
        checkOutput("rr_wreg1", 64'(WReg), 64'd6);
        checkOutput("rr_wdata1", 64'(WDATA), 64'h101);
        @(negedge clk); checkOutput("rr_g2", 64'(req_ready), 64'b100);
        stepClock();
        checkOutput("rr_wr2", 64'(WR), 64'd1);
        checkOutput("rr_wreg2", 64'(WReg), 64'd7);
        checkOutput("rr_wdata2", 64'(WDATA), 64'h102);
        @(negedge clk); checkOutput("rr_g3", 64'(req_ready), 64'b001);
        stepClock();
        checkOutput("rr_wreg3", 64'(WReg), 64'd5);

        // Scoreboard lifecycle on x9 (pointer now at 1)
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
        stepClock();
        checkOutput("sb_busy_set", 64'(busy_vec), 64'h200);
        checkOutput("sb_wr_idle", 64'(WR), 64'd0);
        applyStimulus(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
        @(negedge clk);
        checkOutput("sb_stall_pending", 64'(hazard_stall), 64'd1);
        checkOutput("sb_grant1", 64'(req_ready), 64'b010);
        stepClock();
        checkOutput("sb_wr", 64'(WR), 64'd1);
        checkOutput("sb_wreg", 64'(WReg), 64'd9);
        checkOutput("sb_wdata", 64'(WDATA), 64'hDEADBEEF);
        checkOutput("sb_busy_during_wr", 64'(busy_vec), 64'h200);
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
        @(negedge clk); checkOutput("sb_stall_during_wr", 64'(hazard_stall), 64'd1);
        stepClock();
        checkOutput("sb_busy_clear", 64'(busy_vec), 64'd0);
        checkOutput("sb_wr_off", 64'(WR), 64'd0);
        checkOutput("sb_wreg_hold", 64'(WReg), 64'd9);
        @(negedge clk); checkOutput("sb_stall_drop", 64'(hazard_stall), 64'd0);

        // x0 write from requester 2 (pointer at 2), plus x0 issue
        applyStimulus(3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("x0_grant2", 64'(req_ready), 64'b100);
        checkOutput("x0_stall", 64'(hazard_stall), 64'd0);
        stepClock();
        checkOutput("x0_wr", 64'(WR), 64'd0);
        checkOutput("x0_busy", 64'(busy_vec), 64'd0);
        checkOutput("x0_wdata_hold", 64'(WDATA), 64'hDEADBEEF);
        // Pointer must have advanced to 0: with 1 and 2 valid, 1 wins
        applyStimulus(3'b110, 5'd0, 5'd3, 5'd4, 32'h0, 32'h33, 32'h44, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk); checkOutput("x0_ptr_adv", 64'(req_ready), 64'b010);
        stepClock();
        checkOutput("x0_next_wreg", 64'(WReg), 64'd3);
        applyStimulus(3'b100, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h44, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk); checkOutput("x0_grant2b", 64'(req_ready), 64'b100);
        stepClock();
        checkOutput("x0_wreg4", 64'(WReg), 64'd4);
        checkOutput("x0_wdata44", 64'(WDATA), 64'h44);

        // Simultaneous set and clear on x12 (pointer at 0)
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd12, 5'd0, 5'd0);
        stepClock();
        checkOutput("ss_busy_set", 64'(busy_vec), 64'h1000);
        applyStimulus(3'b001, 5'd12, 5'd0, 5'd0, 32'hC0FFEE, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd12);
        @(negedge clk);
        checkOutput("ss_stall_rs2", 64'(hazard_stall), 64'd1);
        checkOutput("ss_grant0", 64'(req_ready), 64'b001);
        stepClock();
        checkOutput("ss_wreg", 64'(WReg), 64'd12);
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd12, 5'd0, 5'd12);
        stepClock();
        checkOutput("ss_set_wins", 64'(busy_vec), 64'h1000);
        @(negedge clk); checkOutput("ss_stall_kept", 64'(hazard_stall), 64'd1);
        applyStimulus(3'b010, 5'd0, 5'd12, 5'd0, 32'h0, 32'h55, 32'h0, 1'b0, 5'd0, 5'd0, 5'd12);
        @(negedge clk); checkOutput("ss_grant1", 64'(req_ready), 64'b010);
        stepClock();
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        stepClock();
        checkOutput("ss_busy_clear", 64'(busy_vec), 64'd0);

        // Reset mid-operation (pointer at 2)
        applyStimulus(3'b100, 5'd0, 5'd0, 5'd20, 32'h0, 32'h0, 32'hABCD, 1'b1, 5'd21, 5'd0, 5'd0);
        stepClock();
        checkOutput("mr_wr_pre", 64'(WR), 64'd1);
        checkOutput("mr_busy_pre", 64'(busy_vec), 64'h200000);
        rst = 1'b1;
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        stepClock();
        checkOutput("mr_wr", 64'(WR), 64'd0);
        checkOutput("mr_busy", 64'(busy_vec), 64'd0);
        checkOutput("mr_wreg", 64'(WReg), 64'd0);
        checkOutput("mr_wdata", 64'(WDATA), 64'd0);
        rst = 1'b0;
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk); checkOutput("mr_ptr0", 64'(req_ready), 64'b001);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
